// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: decodes load/store accesses, drives the
// data-memory request/response handshake and produces one registered writeback per instruction.
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        e_valid,
    input  logic [31:0] e_alu_res,
    input  logic [31:0] e_rs2_data,
    input  logic [2:0]  e_funct3,
    input  logic        e_mem_read,
    input  logic        e_mem_write,
    input  logic [4:0]  e_rd,
    input  logic        e_reg_write,
    input  logic [1:0]  e_wb_sel,
    input  logic [31:0] e_pc,
    output logic        e_ready,

    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_rsp_valid,
    input  logic [31:0] dm_rdata,

    output logic        w_valid,
    output logic [4:0]  w_rd,
    output logic        w_reg_write,
    output logic [31:0] w_data,
    output logic [31:0] w_pc,
    output logic        w_misaligned,
    output logic        w_bus_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  rd_reg;
    logic        reg_write_reg;
    logic [31:0] pc_reg;
    logic        store_reg;

    logic        e_is_mem;
    logic        e_misaligned;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_wb_data;

    logic [7:0]  rdata_byte [4];
    logic [15:0] rdata_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    assign e_ready  = (state_reg == IDLE);
    assign e_is_mem = e_mem_read | e_mem_write;

    // Unused funct3 encodings fall into the misaligned path so they never reach the bus.
    always_comb begin
        e_misaligned = 1'b0;
        if (e_mem_write) begin
            case (e_funct3)
                3'b000:  e_misaligned = 1'b0;
                3'b001:  e_misaligned = e_alu_res[0];
                3'b010:  e_misaligned = |e_alu_res[1:0];
                default: e_misaligned = 1'b1;
            endcase
        end else if (e_mem_read) begin
            case (e_funct3)
                3'b000, 3'b100: e_misaligned = 1'b0;
                3'b001, 3'b101: e_misaligned = e_alu_res[0];
                3'b010:         e_misaligned = |e_alu_res[1:0];
                default:        e_misaligned = 1'b1;
            endcase
        end
    end

    always_comb begin
        e_wstrb = 4'b1111;
        e_wdata = e_rs2_data;
        case (e_funct3[1:0])
            2'b00: begin
                e_wstrb = 4'b0001 << e_alu_res[1:0];
                e_wdata = {4{e_rs2_data[7:0]}};
            end
            2'b01: begin
                e_wstrb = 4'b0011 << e_alu_res[1:0];
                e_wdata = {2{e_rs2_data[15:0]}};
            end
            default: begin
                e_wstrb = 4'b1111;
                e_wdata = e_rs2_data;
            end
        endcase
    end

    always_comb begin
        e_wb_data = e_alu_res;
        if (e_wb_sel == 2'b10) begin
            e_wb_data = e_pc + 32'd4;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rdata_byte[gi] = dm_rdata[gi*8 +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign rdata_half[gi] = dm_rdata[gi*16 +: 16];
        end
    endgenerate

    always_comb begin
        sel_byte  = rdata_byte[addr_reg[1:0]];
        sel_half  = rdata_half[addr_reg[1]];
        load_data = dm_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_misaligned <= 1'b0;
            w_bus_err    <= 1'b0;
            w_data       <= '0;
            w_pc         <= '0;
            w_rd         <= '0;
            dm_req_valid <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dm_wstrb     <= '0;
        end else begin
            w_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (e_valid) begin
                        addr_reg      <= e_alu_res;
                        funct3_reg    <= e_funct3;
                        rd_reg        <= e_rd;
                        reg_write_reg <= e_reg_write;
                        pc_reg        <= e_pc;
                        store_reg     <= e_mem_write;
                        if (!e_is_mem) begin
                            w_valid      <= 1'b1;
                            w_rd         <= e_rd;
                            w_reg_write  <= e_reg_write;
                            w_data       <= e_wb_data;
                            w_pc         <= e_pc;
                            w_misaligned <= 1'b0;
                            w_bus_err    <= 1'b0;
                        end else if (e_misaligned) begin
                            // Faulting address is reported in w_data for the trap handler.
                            w_valid      <= 1'b1;
                            w_rd         <= e_rd;
                            w_reg_write  <= 1'b0;
                            w_data       <= e_alu_res;
                            w_pc         <= e_pc;
                            w_misaligned <= 1'b1;
                            w_bus_err    <= 1'b0;
                        end else begin
                            state_reg    <= REQ;
                            dm_req_valid <= 1'b1;
                            dm_addr      <= {e_alu_res[31:2], 2'b00};
                            dm_we        <= e_mem_write;
                            dm_wdata     <= e_mem_write ? e_wdata : 32'd0;
                            dm_wstrb     <= e_mem_write ? e_wstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    if (dm_req_ready) begin
                        dm_req_valid <= 1'b0;
                        if (store_reg) begin
                            state_reg    <= IDLE;
                            w_valid      <= 1'b1;
                            w_rd         <= rd_reg;
                            w_reg_write  <= 1'b0;
                            w_data       <= addr_reg;
                            w_pc         <= pc_reg;
                            w_misaligned <= 1'b0;
                            w_bus_err    <= 1'b0;
                        end else begin
                            state_reg    <= WAIT_RSP;
                            wait_cnt_reg <= '0;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the last allowed cycle still completes the load.
                    if (dm_rsp_valid) begin
                        state_reg    <= IDLE;
                        w_valid      <= 1'b1;
                        w_rd         <= rd_reg;
                        w_reg_write  <= reg_write_reg;
                        w_data       <= load_data;
                        w_pc         <= pc_reg;
                        w_misaligned <= 1'b0;
                        w_bus_err    <= 1'b0;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        state_reg    <= IDLE;
                        w_valid      <= 1'b1;
                        w_rd         <= rd_reg;
                        w_reg_write  <= 1'b0;
                        w_data       <= addr_reg;
                        w_pc         <= pc_reg;
                        w_misaligned <= 1'b0;
                        w_bus_err    <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle vectors, load/store sequences,
// timeout and reset corner cases, with a cycle-stamped writeback scoreboard.
module tb_mem_stage;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        e_valid = 1'b0;
    logic [31:0] e_alu_res = '0;
    logic [31:0] e_rs2_data = '0;
    logic [2:0]  e_funct3 = '0;
    logic        e_mem_read = 1'b0;
    logic        e_mem_write = 1'b0;
    logic [4:0]  e_rd = '0;
    logic        e_reg_write = 1'b0;
    logic [1:0]  e_wb_sel = '0;
    logic [31:0] e_pc = '0;
    logic        e_ready;
    logic        dm_req_valid;
    logic        dm_req_ready = 1'b0;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_rsp_valid = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic        w_reg_write;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic        w_misaligned;
    logic        w_bus_err;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .e_valid(e_valid), .e_alu_res(e_alu_res), .e_rs2_data(e_rs2_data),
        .e_funct3(e_funct3), .e_mem_read(e_mem_read), .e_mem_write(e_mem_write),
        .e_rd(e_rd), .e_reg_write(e_reg_write), .e_wb_sel(e_wb_sel), .e_pc(e_pc),
        .e_ready(e_ready),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
        .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
        .w_valid(w_valid), .w_rd(w_rd), .w_reg_write(w_reg_write), .w_data(w_data),
        .w_pc(w_pc), .w_misaligned(w_misaligned), .w_bus_err(w_bus_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic        reg_write;
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] pc;
        logic        mis;
        logic        berr;
        int          cyc;
    } wb_t;

    wb_t exp_q[$];

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  wbsel;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_mis;
        logic        chk;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] wbsel, input logic [31:0] pc);
        e_valid = 1'b1; e_mem_read = mr; e_mem_write = mw; e_funct3 = f3;
        e_alu_res = alu; e_rs2_data = rs2; e_rd = rd; e_reg_write = rw;
        e_wb_sel = wbsel; e_pc = pc;
    endtask

    task automatic expect_wb(input int tag, input logic [4:0] rd, input logic rw, input logic chk,
                             input logic [31:0] data, input logic [31:0] pc, input logic mis,
                             input logic berr, input int lat);
        wb_t e;
        e.tag = tag; e.rd = rd; e.reg_write = rw; e.chk_data = chk; e.data = data;
        e.pc = pc; e.mis = mis; e.berr = berr; e.cyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        wb_t e;
        if (w_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_w_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("wb%0d_cycle", e.tag), cyc, e.cyc);
                check($sformatf("wb%0d_rd", e.tag), w_rd, e.rd);
                check($sformatf("wb%0d_reg_write", e.tag), w_reg_write, e.reg_write);
                check($sformatf("wb%0d_pc", e.tag), w_pc, e.pc);
                check($sformatf("wb%0d_misaligned", e.tag), w_misaligned, e.mis);
                check($sformatf("wb%0d_bus_err", e.tag), w_bus_err, e.berr);
                if (e.chk_data) check($sformatf("wb%0d_data", e.tag), w_data, e.data);
            end
        end
    end

    task automatic do_load(input int tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input logic [4:0] rd);
        logic [31:0] pc;
        pc = 32'h1000 + 32'(tag * 4);
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rdata = rdata;
        drive(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1, 2'b01, pc);
        expect_wb(tag, rd, 1'b1, 1'b1, exp, pc, 1'b0, 1'b0, 3);
        tick;
        e_valid = 1'b0;
        check($sformatf("ld%0d_req_valid", tag), dm_req_valid, 1'b1);
        check($sformatf("ld%0d_addr", tag), dm_addr, {addr[31:2], 2'b00});
        check($sformatf("ld%0d_we", tag), dm_we, 1'b0);
        check($sformatf("ld%0d_wstrb", tag), dm_wstrb, 4'b0000);
        check($sformatf("ld%0d_ready_req", tag), e_ready, 1'b0);
        tick;
        check($sformatf("ld%0d_ready_wait", tag), e_ready, 1'b0);
        check($sformatf("ld%0d_req_dropped", tag), dm_req_valid, 1'b0);
        tick;
        check($sformatf("ld%0d_ready_done", tag), e_ready, 1'b1);
        dm_rsp_valid = 1'b0;
    endtask

    task automatic do_store(input int tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] strb,
                            input logic [31:0] wdata, input int stall);
        logic [31:0] pc;
        pc = 32'h2000 + 32'(tag * 4);
        dm_req_ready = (stall == 0); dm_rsp_valid = 1'b0;
        drive(1'b0, 1'b1, f3, addr, rs2, 5'd3, 1'b1, 2'b00, pc);
        expect_wb(tag, 5'd3, 1'b0, 1'b0, 32'h0, pc, 1'b0, 1'b0, stall + 2);
        tick;
        e_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            check($sformatf("st%0d_c%0d_req_valid", tag, i), dm_req_valid, 1'b1);
            check($sformatf("st%0d_c%0d_addr", tag, i), dm_addr, {addr[31:2], 2'b00});
            check($sformatf("st%0d_c%0d_we", tag, i), dm_we, 1'b1);
            check($sformatf("st%0d_c%0d_wstrb", tag, i), dm_wstrb, strb);
            check($sformatf("st%0d_c%0d_wdata", tag, i), dm_wdata, wdata);
            check($sformatf("st%0d_c%0d_e_ready", tag, i), e_ready, 1'b0);
            if (i == stall) dm_req_ready = 1'b1;
            tick;
        end
        dm_req_ready = 1'b0;
        check($sformatf("st%0d_req_done", tag), dm_req_valid, 1'b0);
        check($sformatf("st%0d_e_ready", tag), e_ready, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0000_0100, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0000_DEAD, 32'h0000_0200, 5'd6, 1'b1, 2'b10, 32'h0000_0204, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0001, 32'hFFFF_FFFC, 5'd7, 1'b1, 2'b10, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h5555_AAAA, 32'h0000_0208, 5'd8, 1'b0, 2'b00, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0000_020C, 5'd9, 1'b1, 2'b01, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0203, 32'h0000_0210, 5'd10, 1'b1, 2'b01, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0102, 32'h0000_0214, 5'd11, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0105, 32'h0000_0218, 5'd12, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0000_021C, 5'd13, 1'b1, 2'b01, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0000_0220, 5'd14, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd5, 32'h0000_0107, 32'h0000_0224, 5'd15, 1'b1, 2'b01, 32'h0, 1'b0, 1'b1, 1'b0};

        tick;
        tick;
        reset = 1'b0;
        check("rst_e_ready", e_ready, 1'b1);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_dm_req_valid", dm_req_valid, 1'b0);
        check("rst_w_data", w_data, 32'h0);
        check("rst_dm_wstrb", dm_wstrb, 4'h0);

        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d_e_ready", i), e_ready, 1'b1);
            drive(vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].alu, 32'h0, vecs[i].rd,
                  vecs[i].rw, vecs[i].wbsel, vecs[i].pc);
            expect_wb(i, vecs[i].rd, vecs[i].exp_rw, vecs[i].chk, vecs[i].exp_data,
                      vecs[i].pc, vecs[i].exp_mis, 1'b0, 1);
            tick;
            check($sformatf("v%0d_no_dm_req", i), dm_req_valid, 1'b0);
        end
        e_valid = 1'b0; e_mem_read = 1'b0; e_mem_write = 1'b0;
        tick;

        do_load(100, 3'b000, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80, 5'd7);
        tick;
        check("hold_w_valid_low", w_valid, 1'b0);
        check("hold_w_data", w_data, 32'hFFFF_FF80);
        do_load(101, 3'b001, 32'h0000_0102, 32'h8001_1234, 32'hFFFF_8001, 5'd8);
        do_load(102, 3'b101, 32'h0000_0102, 32'h8001_1234, 32'h0000_8001, 5'd9);
        do_load(103, 3'b100, 32'h0000_0101, 32'h0000_AB00, 32'h0000_00AB, 5'd10);
        do_load(104, 3'b000, 32'h0000_0100, 32'h0000_007F, 32'h0000_007F, 5'd11);
        do_load(105, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd12);
        do_load(106, 3'b001, 32'h0000_0100, 32'h1234_7FFF, 32'h0000_7FFF, 5'd13);

        do_store(200, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF, 4);
        do_store(201, 3'b000, 32'h0000_0101, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A, 0);
        do_store(202, 3'b000, 32'h0000_0103, 32'h0000_00C3, 4'b1000, 32'hC3C3_C3C3, 0);
        do_store(203, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);
        do_store(204, 3'b001, 32'h0000_0100, 32'h0000_7654, 4'b0011, 32'h7654_7654, 0);

        // Timeout after MW cycles in WAIT_RSP, then a late response must be dropped.
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 2'b01, 32'h0000_0500);
        expect_wb(300, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0000_0500, 1'b0, 1'b1, 2 + MW);
        tick;
        e_valid = 1'b0;
        tick;
        for (int i = 0; i < MW; i++) begin
            check($sformatf("to_c%0d_e_ready", i), e_ready, 1'b0);
            check($sformatf("to_c%0d_w_valid", i), w_valid, 1'b0);
            tick;
        end
        check("to_bus_err", w_bus_err, 1'b1);
        dm_rsp_valid = 1'b1; dm_rdata = 32'h1111_2222;
        tick;
        check("late_rsp_w_valid_0", w_valid, 1'b0);
        tick;
        dm_rsp_valid = 1'b0;
        check("late_rsp_w_valid_1", w_valid, 1'b0);
        check("late_rsp_bus_err_held", w_bus_err, 1'b1);

        // Response on the final allowed cycle wins over the timeout.
        dm_req_ready = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 5'd10, 1'b1, 2'b01, 32'h0000_0600);
        expect_wb(301, 5'd10, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h0000_0600, 1'b0, 1'b0, 2 + MW);
        tick;
        e_valid = 1'b0;
        for (int i = 0; i < MW; i++) tick;
        dm_rsp_valid = 1'b1; dm_rdata = 32'h0BAD_F00D;
        tick;
        dm_rsp_valid = 1'b0;

        // Reset during WAIT_RSP aborts the load silently.
        dm_req_ready = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0308, 32'h0, 5'd11, 1'b1, 2'b01, 32'h0000_0700);
        tick;
        e_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rw_w_valid", w_valid, 1'b0);
        check("rw_w_data", w_data, 32'h0);
        check("rw_w_pc", w_pc, 32'h0);
        check("rw_w_rd", w_rd, 5'd0);
        check("rw_w_reg_write", w_reg_write, 1'b0);
        check("rw_w_flags", {w_misaligned, w_bus_err}, 2'b00);
        check("rw_dm_req_valid", dm_req_valid, 1'b0);
        check("rw_dm_we", dm_we, 1'b0);
        check("rw_dm_addr", dm_addr, 32'h0);
        check("rw_dm_wdata", dm_wdata, 32'h0);
        check("rw_dm_wstrb", dm_wstrb, 4'h0);
        check("rw_e_ready", e_ready, 1'b1);
        dm_rsp_valid = 1'b1; dm_rdata = 32'h3333_4444;
        tick;
        dm_rsp_valid = 1'b0;
        check("rw_late_w_valid", w_valid, 1'b0);
        check("rw_e_ready_next", e_ready, 1'b1);

        // Reset during REQ drops the request on the next cycle.
        dm_req_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h5, 5'd1, 1'b0, 2'b00, 32'h0000_0800);
        tick;
        e_valid = 1'b0;
        check("rq_req_valid", dm_req_valid, 1'b1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rq_req_dropped", dm_req_valid, 1'b0);
        check("rq_e_ready", e_ready, 1'b1);
        tick;
        tick;
        check("rq_no_w_valid", w_valid, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: number of WAIT_RSP cycles allowed before bus timeout.
REQ-002 SHALL have port clock  input  1  system clock; reset is synchronous, active-high, sampled on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have execute-side inputs, each a single port:
- e_valid 1: instruction present
- e_alu_res 32: address or ALU result
- e_rs2_data 32: store data
- e_funct3 3
- e_mem_read 1
- e_mem_write 1
- e_rd 5
- e_reg_write 1
- e_wb_sel 2: 00=ALU, 01=load, 10=pc+4
- e_pc 32
REQ-005 SHALL have port e_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have data-memory ports:
- dm_req_valid out 1
- dm_req_ready in 1
- dm_addr out 32: word-aligned, [1:0]=0
- dm_we out 1
- dm_wdata out 32
- dm_wstrb out 4
- dm_rsp_valid in 1
- dm_rdata in 32
REQ-007 SHALL have writeback outputs, each a single registered port:
- w_valid 1
- w_rd 5
- w_reg_write 1
- w_data 32
- w_pc 32
- w_misaligned 1
- w_bus_err 1

Function
REQ-008 SHALL implement FSM states IDLE, REQ and WAIT_RSP; e_ready=1 only in IDLE.
REQ-009 Acceptance SHALL occur when e_valid && e_ready; all e_* fields are captured into internal registers on acceptance.
REQ-010 A non-memory instruction (e_mem_read=e_mem_write=0) SHALL stay in IDLE and produce a w_valid pulse on the next cycle (latency 1), with:
- wb_sel 00: w_data = e_alu_res
- wb_sel 10: w_data = e_pc+4, mod 2^32
REQ-011 Misalignment SHALL be detected as: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
REQ-012 A misaligned access SHALL issue no dm request and SHALL produce, one cycle later, w_valid=1, w_misaligned=1, w_reg_write=0.
REQ-013 An aligned memory access SHALL move IDLE->REQ.
- REQ drives dm_req_valid=1 with stable dm_addr={addr[31:2],2'b00}, dm_we, dm_wdata and dm_wstrb until the cycle dm_req_ready=1.
REQ-014 Store strobes and data SHALL be:
- sb: wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}
- sh: wstrb=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}
- sw: wstrb=4'b1111, wdata=rs2
REQ-015 Stores SHALL be posted: on the REQ handshake, FSM->IDLE and w_valid pulses next cycle with w_reg_write=0.
REQ-016 Loads SHALL go REQ->WAIT_RSP on the handshake and drive dm_wstrb=4'b0000, dm_we=0.
REQ-017 In WAIT_RSP, the first dm_rsp_valid=1 SHALL capture the load result, FSM->IDLE, and w_valid pulses next cycle.
REQ-018 Load data SHALL select the byte/half at addr[1:0] from dm_rdata:
- lb/lh: sign-extend
- lbu/lhu: zero-extend
- lw: whole word
REQ-019 Minimum load latency, acceptance to w_valid, SHALL be 3 cycles (dm_req_ready=1 and dm_rsp_valid=1 each on the first possible cycle).
REQ-020 A WAIT_RSP wait counter SHALL clear on entry and increment each cycle without a response.
- On reaching MAX_WAIT: FSM->IDLE; w_valid=1, w_bus_err=1, w_reg_write=0.
REQ-021 dm_rsp_valid SHALL be ignored outside WAIT_RSP, so late responses are dropped.
REQ-022 A response and the timeout in the same cycle SHALL resolve in favour of the response.
REQ-023 Unused funct3 codes with mem_read or mem_write SHALL be treated as misaligned, per REQ-012.
REQ-024 w_valid SHALL be a one-cycle pulse; w_rd, w_data, w_pc and the flags hold their values until the next w_valid.
REQ-025 e_ready SHALL be 0 in REQ and WAIT_RSP, including the cycle of the dm handshake, so the upstream stage is stalled.

Reset
REQ-026 When reset=1, the block SHALL on the next edge:
- set FSM=IDLE and wait counter=0
- clear w_valid, w_reg_write, w_misaligned, w_bus_err, dm_req_valid and dm_we to 0
- clear w_data, w_pc, w_rd, dm_addr, dm_wdata and dm_wstrb to 0
REQ-027 Reset asserted in REQ or WAIT_RSP SHALL abort the access with no w_valid; dm_req_valid is 0 from the cycle after reset is sampled.
REQ-028 e_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-029 The bench SHALL cover: ALU op, rd=5, e_alu_res=0x1234, wb_sel=00 -> w_valid next cycle, w_data=0x1234, w_reg_write=1.
REQ-030 The bench SHALL cover: lb at addr 0x103, dm_rdata=0x80FFFFFF, zero-latency memory -> w_data=0xFFFFFF80 exactly 3 cycles after acceptance.
REQ-031 The bench SHALL cover: sh at addr 0x102, rs2=0xAAAABEEF, dm_req_ready held low 4 cycles -> dm_addr=0x100, wstrb=1100, wdata=0xBEEFBEEF stable 5 cycles, e_ready=0 throughout.
REQ-032 The bench SHALL cover: lw at addr 0x101 -> no dm_req_valid; w_misaligned=1 and w_reg_write=0 next cycle.
REQ-033 The bench SHALL cover: lw with no response, MAX_WAIT=4 -> w_bus_err=1 after 4 WAIT_RSP cycles; a later dm_rsp_valid produces no w_valid.
REQ-034 The bench SHALL cover: reset asserted during WAIT_RSP -> no w_valid, all outputs 0, e_ready=1 the cycle after reset deasserts.
